// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with exact flags, occupancy count and overflow/underflow strobes.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise reads are registered (1-cycle latency).
`timescale 1ns/1ps
module fifo_sync_param #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned ADDR_W   = 4,
    parameter int unsigned AF_LEVEL = 14,
    parameter int unsigned AE_LEVEL = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_en,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_rd_en,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_dout,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_almost_empty,
    output logic              o_almost_full,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_underflow
);

    localparam int unsigned     DEPTH    = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] LP_AF    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] LP_AE    = (ADDR_W + 1)'(AE_LEVEL);
    localparam logic [ADDR_W:0] LP_ONE   = (ADDR_W + 1)'(1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W:0]   r_wr_ptr;
    logic [ADDR_W:0]   r_rd_ptr;
    logic              r_empty;
    logic              r_full;
    logic              r_ae;
    logic              r_af;
    logic              r_ovf;
    logic              r_udf;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic [ADDR_W:0]   w_wr_ptr_nxt;
    logic [ADDR_W:0]   w_rd_ptr_nxt;
    logic [ADDR_W:0]   w_count_nxt;

    // Occupancy is the wrap-aware pointer distance; flags are precomputed from the next count.
    always_comb begin
        w_wr_acc     = i_wr_en & ~r_full;
        w_rd_acc     = i_rd_en & ~r_empty;
        w_wr_ptr_nxt = r_wr_ptr + (w_wr_acc ? LP_ONE : '0);
        w_rd_ptr_nxt = r_rd_ptr + (w_rd_acc ? LP_ONE : '0);
        w_count_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ae     <= 1'b1;
            r_af     <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_empty  <= (w_count_nxt == '0);
            r_full   <= (w_count_nxt == LP_DEPTH);
            r_ae     <= (w_count_nxt <= LP_AE);
            r_af     <= (w_count_nxt >= LP_AF);
            r_ovf    <= i_wr_en & r_full;
            r_udf    <= i_rd_en & r_empty;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_wr_acc) begin
            r_mem[r_wr_ptr[ADDR_W-1:0]] <= i_din;
        end
    end

`ifdef FIFO_FWFT_EN
    // Head word is shown combinationally from the array; zero while nothing is stored.
    always_comb begin
        o_valid = ~r_empty;
        o_dout  = r_empty ? '0 : r_mem[r_rd_ptr[ADDR_W-1:0]];
    end
`else
    logic              r_valid;
    logic [DATA_W-1:0] r_dout;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_dout  <= '0;
        end else begin
            r_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_dout <= r_mem[r_rd_ptr[ADDR_W-1:0]];
            end
        end
    end

    always_comb begin
        o_valid = r_valid;
        o_dout  = r_dout;
    end
`endif

    always_comb begin
        o_empty        = r_empty;
        o_full         = r_full;
        o_almost_empty = r_ae;
        o_almost_full  = r_af;
        o_count        = r_wr_ptr - r_rd_ptr;
        o_overflow     = r_ovf;
        o_underflow    = r_udf;
    end

endmodule
